// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 memory responder.
package z80_bus_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [7:0] DEF_IO_PAGE     = 8'h10;
   localparam logic [7:0] DEF_INTA_VECTOR = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      DATA,
      HOLD
   } state_t;

   typedef enum logic [2:0] {
      MEM_RD,
      MEM_WR,
      IO_RD,
      IO_WR,
      INTA
   } cyc_t;

   // True for IO read/write cycles (interrupt acknowledge excluded).
   function automatic logic is_io(input cyc_t c);
      return (c == IO_RD) || (c == IO_WR);
   endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Classifies the Z80 bus strobes into a cycle type; purely combinational.
module z80_cycle_decode
   import z80_bus_pkg::*;
(
   input  logic m1_n,
   input  logic mreq_n,
   input  logic iorq_n,
   input  logic rd_n,
   input  logic rfsh_n,
   output logic cyc_valid_c,
   output cyc_t cyc_type_c
);

   // Priority: interrupt acknowledge, then memory (refresh excluded), then IO.
   always_comb begin
      cyc_valid_c = 1'b0;
      cyc_type_c  = MEM_RD;
      if (!m1_n && !iorq_n) begin
         cyc_valid_c = 1'b1;
         cyc_type_c  = INTA;
      end else if (!mreq_n && rfsh_n) begin
         cyc_valid_c = 1'b1;
         cyc_type_c  = rd_n ? MEM_WR : MEM_RD;
      end else if (!iorq_n) begin
         cyc_valid_c = 1'b1;
         cyc_type_c  = rd_n ? IO_WR : IO_RD;
      end
   end

endmodule

// File: rtl/z80_mem_responder.sv
// Z80 bus slave that serves memory, IO and interrupt-acknowledge cycles
// from a synchronous RAM port with optional wait-state insertion.
// Define Z80_RESP_IO_EN to map IO cycles onto RAM page IO_PAGE; without it
// IO reads return 8'hFF, IO writes are dropped and IO cycles get no waits.
module z80_mem_responder
   import z80_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [7:0]  INTA_VECTOR = DEF_INTA_VECTOR,
   parameter logic [7:0]  IO_PAGE     = DEF_IO_PAGE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   output logic [7:0]  di,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   output logic        wait_n,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        ram_we,
   output logic        ram_re,
   input  logic [7:0]  ram_rdata
);

`ifdef Z80_RESP_IO_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   state_t           state;
   cyc_t             cyc;
   logic [CNT_W-1:0] wait_cnt;
   logic             armed;
   logic             re_d;
   logic [7:0]       rd_buf;

   logic             cyc_valid_c;
   cyc_t             cyc_type_c;
   logic             strobes_idle_c;
   logic             wants_wait_c;
   logic             write_ok_c;
   logic             write_now_c;
   logic [7:0]       rd_data_c;

   z80_cycle_decode u_decode (
      .m1_n        (m1_n),
      .mreq_n      (mreq_n),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .rfsh_n      (rfsh_n),
      .cyc_valid_c (cyc_valid_c),
      .cyc_type_c  (cyc_type_c)
   );

   // Cycle qualifiers; RAM data is only valid the clock after ram_re, so a
   // buffered copy covers reads stretched by wait states.
   always_comb begin
      strobes_idle_c = mreq_n && iorq_n;
      wants_wait_c   = (WAIT_STATES > 0) && (IO_EN || !is_io(cyc_type_c));
      write_ok_c     = (cyc == MEM_WR) || (IO_EN && (cyc == IO_WR));
      write_now_c    = write_ok_c && !wr_n && (state inside {ADDR, WAIT, DATA});
      rd_data_c      = re_d ? ram_rdata : rd_buf;
   end

   // Bus FSM with wait counter and registered RAM port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cyc       <= MEM_RD;
         wait_cnt  <= '0;
         armed     <= 1'b0;
         re_d      <= 1'b0;
         rd_buf    <= '0;
         di        <= 8'hFF;
         wait_n    <= 1'b1;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_we <= 1'b0;
         ram_re <= 1'b0;
         re_d   <= ram_re;
         if (re_d) rd_buf <= ram_rdata;

         if (strobes_idle_c) begin
            armed    <= 1'b1;
            state    <= IDLE;
            wait_n   <= 1'b1;
            wait_cnt <= '0;
         end else begin
            if (!wait_n) begin
               if (wait_cnt == '0) wait_n <= 1'b1;
               else                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (write_now_c) begin
               ram_we    <= 1'b1;
               ram_wdata <= dout;
               state     <= HOLD;
            end else begin
               case (state)
                  IDLE: begin
                     if (armed && cyc_valid_c) begin
                        armed    <= 1'b0;
                        cyc      <= cyc_type_c;
                        state    <= ADDR;
                        ram_addr <= is_io(cyc_type_c) ? {IO_PAGE, A[7:0]} : A;
                        ram_re   <= (cyc_type_c == MEM_RD) ||
                                    (IO_EN && (cyc_type_c == IO_RD));
                        if (wants_wait_c) begin
                           wait_n   <= 1'b0;
                           wait_cnt <= WAIT_LOAD;
                        end
                     end
                  end
                  ADDR: state <= wait_n ? DATA : WAIT;
                  WAIT: if (wait_n) state <= DATA;
                  DATA: begin
                     if (!write_ok_c) begin
                        case (cyc)
                           MEM_RD:  di <= rd_data_c;
                           IO_RD:   di <= IO_EN ? rd_data_c : 8'hFF;
                           INTA:    di <= INTA_VECTOR;
                           default: di <= di;
                        endcase
                        state <= HOLD;
                     end
                  end
                  default: state <= state;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench for z80_mem_responder: a zero-wait instance and a
// three-wait instance share the CPU bus, each with its own RAM model.
`timescale 1ns/1ps
module tb_z80_mem_responder;

`ifdef Z80_RESP_IO_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] A;
   logic [7:0]  dout;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;

   logic [7:0]  di0, di3;
   logic        wait_n0, wait_n3;
   logic [15:0] addr0, addr3;
   logic [7:0]  wdata0, wdata3;
   logic        we0, we3, re0, re3;
   logic [7:0]  rdata0, rdata3;

   logic        pl_we;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;

   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem3 [0:65535];
   int          we_cnt0, re_cnt0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   z80_mem_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .A(A), .dout(dout), .di(di0),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .rfsh_n(rfsh_n), .wait_n(wait_n0), .ram_addr(addr0), .ram_wdata(wdata0),
      .ram_we(we0), .ram_re(re0), .ram_rdata(rdata0)
   );

   z80_mem_responder #(.WAIT_STATES(3), .INTA_VECTOR(8'hD7)) dut3 (
      .clk(clk), .reset(reset), .A(A), .dout(dout), .di(di3),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .rfsh_n(rfsh_n), .wait_n(wait_n3), .ram_addr(addr3), .ram_wdata(wdata3),
      .ram_we(we3), .ram_re(re3), .ram_rdata(rdata3)
   );

   // Synchronous RAM models with a bench preload port.
   always @(posedge clk) begin
      if (pl_we) begin
         mem0[pl_addr] <= pl_data;
         mem3[pl_addr] <= pl_data;
      end else begin
         if (we0) mem0[addr0] <= wdata0;
         if (we3) mem3[addr3] <= wdata3;
      end
      if (re0) rdata0 <= mem0[addr0];
      if (re3) rdata3 <= mem3[addr3];
   end

   // Strobe pulse counters for the zero-wait instance.
   always @(posedge clk) begin
      if (reset) begin
         we_cnt0 <= 0;
         re_cnt0 <= 0;
      end else begin
         if (we0) we_cnt0 <= we_cnt0 + 1;
         if (re0) re_cnt0 <= re_cnt0 + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic m1, input logic mreq, input logic iorq,
                          input logic rd, input logic wr, input logic rfsh);
      m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr; rfsh_n = rfsh;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_we = 1'b0;
   endtask

   int base_we, base_re, lows;

   initial begin
      reset = 1'b1; A = '0; dout = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      set_bus(1, 1, 1, 1, 1, 1);
      tick(); tick();
      check_eq("rst_di",     32'(di0),     32'hFF);
      check_eq("rst_wait",   32'(wait_n0), 32'h1);
      check_eq("rst_we",     32'(we0),     32'h0);
      check_eq("rst_re",     32'(re0),     32'h0);
      check_eq("rst_addr",   32'(addr0),   32'h0);
      check_eq("rst_wdata",  32'(wdata0),  32'h0);
      reset = 1'b0;
      preload(16'h9F9B, 8'hF6);
      preload(16'h1042, 8'h77);
      preload(16'h0055, 8'hA7);
      tick();

      // Zero-wait memory read.
      base_re = re_cnt0;
      A = 16'h9F9B; set_bus(1, 0, 1, 0, 1, 1);
      tick();
      check_eq("mrd_re_addr", 32'(re0),     32'h1);
      check_eq("mrd_addr",    32'(addr0),   32'h9F9B);
      check_eq("mrd_wait",    32'(wait_n0), 32'h1);
      tick();
      check_eq("mrd_re_drop", 32'(re0),     32'h0);
      tick();
      check_eq("mrd_di",      32'(di0),     32'hF6);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();
      check_eq("mrd_re_count", 32'(re_cnt0 - base_re), 32'h1);

      // Memory write with wr_n held low for three clocks.
      base_we = we_cnt0;
      A = 16'h1234; dout = 8'h5A; set_bus(1, 0, 1, 1, 1, 1);
      tick();
      wr_n = 1'b0;
      tick();
      check_eq("mwr_we",    32'(we0),    32'h1);
      check_eq("mwr_addr",  32'(addr0),  32'h1234);
      check_eq("mwr_wdata", 32'(wdata0), 32'h5A);
      tick(); tick();
      set_bus(1, 1, 1, 1, 1, 1);
      tick();
      check_eq("mwr_pulses", 32'(we_cnt0 - base_we), 32'h1);
      check_eq("mwr_ram",    32'(mem0[16'h1234]),    32'h5A);

      // IO write then IO read of port 0x42.
      A = 16'h0042; dout = 8'hC3; set_bus(1, 1, 0, 1, 1, 1);
      tick();
      wr_n = 1'b0;
      tick();
      check_eq("iowr_we", 32'(we0), IO_EN ? 32'h1 : 32'h0);
      tick(); tick();
      set_bus(1, 1, 1, 1, 1, 1);
      tick();
      set_bus(1, 1, 0, 0, 1, 1);
      tick(); tick(); tick();
      check_eq("iord_di",  32'(di0), IO_EN ? 32'hC3 : 32'hFF);
      check_eq("iord_ram", 32'(mem0[16'h1042]), IO_EN ? 32'hC3 : 32'h77);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();

      // Three wait states on a memory read.
      lows = 0;
      A = 16'h0055; set_bus(1, 0, 1, 0, 1, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) check_eq("ws3_wait_in_addr", 32'(wait_n3), 32'h0);
         if (!wait_n3) lows++;
      end
      check_eq("ws3_wait_clocks", 32'(lows), 32'h3);
      check_eq("ws3_di",          32'(di3),  32'hA7);
      check_eq("ws0_di_0055",     32'(di0),  32'hA7);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();

      // Strobes released while waits are pending.
      set_bus(1, 0, 1, 0, 1, 1);
      tick(); tick();
      set_bus(1, 1, 1, 1, 1, 1);
      tick();
      check_eq("ws3_abort_wait", 32'(wait_n3), 32'h1);
      tick();
      check_eq("ws3_abort_hold", 32'(wait_n3), 32'h1);

      // Refresh cycle must be ignored.
      base_we = we_cnt0; base_re = re_cnt0;
      A = 16'h007F; set_bus(1, 0, 1, 1, 1, 0);
      tick(); tick(); tick();
      check_eq("rfsh_re", 32'(re_cnt0 - base_re), 32'h0);
      check_eq("rfsh_we", 32'(we_cnt0 - base_we), 32'h0);
      check_eq("rfsh_di", 32'(di0),               32'hA7);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();

      // Reset on the clock wr_n falls, then strobes held low.
      A = 16'h2222; dout = 8'h11; set_bus(1, 0, 1, 1, 1, 1);
      tick();
      base_we = we_cnt0;
      wr_n = 1'b0; reset = 1'b1;
      tick();
      check_eq("mrst_we",    32'(we0),     32'h0);
      check_eq("mrst_di",    32'(di0),     32'hFF);
      check_eq("mrst_wait",  32'(wait_n0), 32'h1);
      check_eq("mrst_re",    32'(re0),     32'h0);
      check_eq("mrst_addr",  32'(addr0),   32'h0);
      check_eq("mrst_wdata", 32'(wdata0),  32'h0);
      reset = 1'b0;
      tick(); tick();
      check_eq("mrst_no_write", 32'(we_cnt0), 32'h0);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();

      // Interrupt acknowledge.
      base_re = re_cnt0; base_we = we_cnt0;
      set_bus(0, 1, 0, 1, 1, 1);
      for (int i = 0; i < 6; i++) tick();
      check_eq("inta_di0", 32'(di0), 32'hFF);
      check_eq("inta_di3", 32'(di3), 32'hD7);
      check_eq("inta_re",  32'(re_cnt0 - base_re), 32'h0);
      check_eq("inta_we",  32'(we_cnt0 - base_we), 32'h0);
      set_bus(1, 1, 1, 1, 1, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
